// File: rtl/pc_control_unit.sv
// rtl/pc_control_unit.sv - PC sequencing with branch/JAL/JALR resolution and misalign trap
// Optional statistics counters are enabled with the BRANCH_STATS_EN macro.
package pc_control_pkg;
  typedef enum logic [2:0] {
    OP_BEQ      = 3'd0,
    OP_BNE      = 3'd1,
    OP_BLT      = 3'd2,
    OP_BGE      = 3'd3,
    OP_BLTU     = 3'd4,
    OP_BGEU     = 3'd5,
    OP_BUNKNOWN = 3'd7
  } comp_select_e;
endpackage

module pc_control_unit
  import pc_control_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'('h100)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            br_valid_i,
  output logic            br_ready_o,
  input  logic [1:0]      br_kind_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] imm_i,
  output comp_select_e    comp_sel_o,
  input  logic            comp_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] link_o,
  output logic            link_valid_o,
  output logic            redirect_o,
  output logic            misalign_o,
  input  logic            trap_ack_i,
  output logic [31:0]     br_count_o,
  output logic [31:0]     br_taken_o
);

  typedef enum logic [1:0] {S_RUN, S_RESOLVE, S_TRAP} state_e;

  localparam logic [1:0] K_BRANCH = 2'b00;
  localparam logic [1:0] K_JAL    = 2'b01;
  localparam logic [1:0] K_JALR   = 2'b10;

  state_e          state_q;
  logic [XLEN-1:0] pc_q, imm_q, rs1_q, link_q;
  logic [1:0]      kind_q;
  comp_select_e    sel_q, sel_d;
  logic            redirect_q, link_valid_q, misalign_q;
  logic [XLEN-1:0] target;
  logic            taken, resolve;

  always_comb begin
    sel_d = OP_BUNKNOWN;
    if (br_kind_i == K_BRANCH) begin
      case (funct3_i)
        3'b000:  sel_d = OP_BEQ;
        3'b001:  sel_d = OP_BNE;
        3'b100:  sel_d = OP_BLT;
        3'b101:  sel_d = OP_BGE;
        3'b110:  sel_d = OP_BLTU;
        3'b111:  sel_d = OP_BGEU;
        default: sel_d = OP_BUNKNOWN;
      endcase
    end
  end

  // PC is frozen while resolving, so pc_q doubles as the captured request PC.
  always_comb begin
    target = ((kind_q == K_JALR) ? rs1_q : pc_q) + imm_q;
    if (kind_q == K_JALR) target[0] = 1'b0;
    case (kind_q)
      K_BRANCH:     taken = comp_i && (sel_q != OP_BUNKNOWN);
      K_JAL, K_JALR: taken = 1'b1;
      default:      taken = 1'b0;
    endcase
  end

  assign resolve = (state_q == S_RESOLVE) && !stall_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC;
      imm_q        <= '0;
      rs1_q        <= '0;
      kind_q       <= K_BRANCH;
      sel_q        <= OP_BUNKNOWN;
      link_q       <= '0;
      link_valid_q <= 1'b0;
      redirect_q   <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      redirect_q   <= 1'b0;
      link_valid_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (!stall_i) begin
            if (br_valid_i) begin
              imm_q   <= imm_i;
              rs1_q   <= rs1_i;
              kind_q  <= br_kind_i;
              sel_q   <= sel_d;
              state_q <= S_RESOLVE;
            end else begin
              pc_q <= pc_q + XLEN'(4);
            end
          end
        end
        S_RESOLVE: begin
          if (!stall_i) begin
            sel_q <= OP_BUNKNOWN;
            if (kind_q == K_JAL || kind_q == K_JALR) begin
              link_q       <= pc_q + XLEN'(4);
              link_valid_q <= 1'b1;
            end
            if (taken && target[1:0] != 2'b00) begin
              misalign_q <= 1'b1;
              state_q    <= S_TRAP;
            end else if (taken) begin
              pc_q       <= target;
              redirect_q <= 1'b1;
              state_q    <= S_RUN;
            end else begin
              pc_q    <= pc_q + XLEN'(4);
              state_q <= S_RUN;
            end
          end
        end
        S_TRAP: begin
          if (trap_ack_i) begin
            pc_q       <= TRAP_VEC;
            misalign_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign br_ready_o   = (state_q == S_RUN) && !stall_i;
  assign comp_sel_o   = sel_q;
  assign pc_o         = pc_q;
  assign link_o       = link_q;
  assign link_valid_o = link_valid_q;
  assign redirect_o   = redirect_q;
  assign misalign_o   = misalign_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_q, br_taken_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_count_q <= '0;
      br_taken_q <= '0;
    end else if (resolve && kind_q == K_BRANCH) begin
      br_count_q <= br_count_q + 32'd1;
      if (taken) br_taken_q <= br_taken_q + 32'd1;
    end
  end

  assign br_count_o = br_count_q;
  assign br_taken_o = br_taken_q;
`else
  assign br_count_o = '0;
  assign br_taken_o = '0;
`endif

endmodule

// File: tb/tb_pc_control_unit.sv
// tb/tb_pc_control_unit.sv - directed self-checking bench for pc_control_unit
module tb_pc_control_unit;
  import pc_control_pkg::*;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i, stall_i, br_valid_i, comp_i, trap_ack_i;
  logic         br_ready_o, link_valid_o, redirect_o, misalign_o;
  logic [1:0]   br_kind_i;
  logic [2:0]   funct3_i;
  logic [31:0]  rs1_i, imm_i, pc_o, link_o, br_count_o, br_taken_o;
  comp_select_e comp_sel_o;

  int n_checks = 0;
  int n_fail   = 0;

  pc_control_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
    .br_valid_i(br_valid_i), .br_ready_o(br_ready_o), .br_kind_i(br_kind_i),
    .funct3_i(funct3_i), .rs1_i(rs1_i), .imm_i(imm_i),
    .comp_sel_o(comp_sel_o), .comp_i(comp_i), .pc_o(pc_o),
    .link_o(link_o), .link_valid_o(link_valid_o), .redirect_o(redirect_o),
    .misalign_o(misalign_o), .trap_ack_i(trap_ack_i),
    .br_count_o(br_count_o), .br_taken_o(br_taken_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic issue(input logic [1:0] kind, input logic [2:0] f3,
                       input logic [31:0] rs1, input logic [31:0] imm);
    br_valid_i = 1'b1;
    br_kind_i  = kind;
    funct3_i   = f3;
    rs1_i      = rs1;
    imm_i      = imm;
    step();
    br_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got 0x0 expected 0x1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; br_valid_i = 1'b0; comp_i = 1'b0; trap_ack_i = 1'b0;
    br_kind_i = 2'b11; funct3_i = 3'b000; rs1_i = '0; imm_i = '0;

    step();
    chk("rst_pc", pc_o, 64'h0);
    chk("rst_redirect", redirect_o, 0);
    chk("rst_link_valid", link_valid_o, 0);
    chk("rst_link", link_o, 0);
    chk("rst_misalign", misalign_o, 0);
    chk("rst_comp_sel", comp_sel_o, OP_BUNKNOWN);
    chk("rst_count", br_count_o, 0);
    chk("rst_taken", br_taken_o, 0);
    rst_i = 1'b0;
    chk("release_ready", br_ready_o, 1);

    for (int i = 1; i <= 4; i++) begin
      step();
      chk("seq_pc", pc_o, 64'(4 * i));
    end

    // BEQ taken at 0x10
    comp_i = 1'b1;
    issue(2'b00, 3'b000, 32'h0, 32'h20);
    chk("beq_sel", comp_sel_o, OP_BEQ);
    chk("beq_hold_pc", pc_o, 64'h10);
    chk("beq_ready", br_ready_o, 0);
    step();
    chk("beq_pc", pc_o, 64'h30);
    chk("beq_redirect", redirect_o, 1);
    chk("beq_sel_after", comp_sel_o, OP_BUNKNOWN);
    chk("beq_count", br_count_o, STATS ? 1 : 0);
    chk("beq_taken", br_taken_o, STATS ? 1 : 0);
    step();
    chk("beq_redirect_drop", redirect_o, 0);
    chk("beq_pc_next", pc_o, 64'h34);

    // BLTU not taken at 0x10, then funct3=010 with comp_i=1
    do_reset();
    repeat (4) step();
    chk("pc_0x10", pc_o, 64'h10);
    comp_i = 1'b0;
    issue(2'b00, 3'b110, 32'h0, 32'h20);
    chk("bltu_sel", comp_sel_o, OP_BLTU);
    step();
    chk("bltu_pc", pc_o, 64'h14);
    chk("bltu_redirect", redirect_o, 0);
    comp_i = 1'b1;
    issue(2'b00, 3'b010, 32'h0, 32'h20);
    chk("unk_sel", comp_sel_o, OP_BUNKNOWN);
    step();
    chk("unk_pc", pc_o, 64'h18);
    chk("unk_redirect", redirect_o, 0);
    chk("nt_count", br_count_o, STATS ? 2 : 0);
    chk("nt_taken", br_taken_o, 0);

    // JALR to misaligned 0x102 traps
    issue(2'b10, 3'b000, 32'h103, 32'h0);
    chk("jalr_sel", comp_sel_o, OP_BUNKNOWN);
    step();
    chk("jalr_misalign", misalign_o, 1);
    chk("jalr_pc_hold", pc_o, 64'h18);
    chk("jalr_redirect", redirect_o, 0);
    chk("jalr_link_valid", link_valid_o, 1);
    chk("jalr_link", link_o, 64'h1C);
    step();
    chk("trap_misalign_held", misalign_o, 1);
    chk("trap_ready", br_ready_o, 0);
    trap_ack_i = 1'b1;
    step();
    trap_ack_i = 1'b0;
    chk("trap_pc", pc_o, 64'h100);
    chk("trap_misalign_clr", misalign_o, 0);
    chk("trap_ready_after", br_ready_o, 1);
    chk("jalr_count", br_count_o, STATS ? 2 : 0);

    // trap_ack outside TRAP ignored; then JAL at 0x40 with 2 stall cycles
    do_reset();
    trap_ack_i = 1'b1;
    step();
    trap_ack_i = 1'b0;
    chk("ack_ignored", pc_o, 64'h4);
    repeat (15) step();
    chk("pc_0x40", pc_o, 64'h40);
    issue(2'b01, 3'b000, 32'h0, 32'hFFFF_FFF8);
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_pc", pc_o, 64'h40);
      chk("stall_redirect", redirect_o, 0);
      chk("stall_link_valid", link_valid_o, 0);
    end
    stall_i = 1'b0;
    step();
    chk("jal_pc", pc_o, 64'h38);
    chk("jal_redirect", redirect_o, 1);
    chk("jal_link", link_o, 64'h44);
    chk("jal_link_valid", link_valid_o, 1);
    step();
    chk("jal_link_valid_drop", link_valid_o, 0);
    chk("jal_pc_next", pc_o, 64'h3C);

    // asynchronous reset during RESOLVE
    comp_i = 1'b1;
    issue(2'b00, 3'b000, 32'h0, 32'h20);
    chk("pre_rst_sel", comp_sel_o, OP_BEQ);
    rst_i = 1'b1;
    #1;
    chk("async_pc", pc_o, 64'h0);
    chk("async_sel", comp_sel_o, OP_BUNKNOWN);
    step();
    rst_i = 1'b0;
    chk("post_rst_redirect", redirect_o, 0);
    step();
    chk("post_rst_pc", pc_o, 64'h4);
    chk("post_rst_redirect2", redirect_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
